spv_input_debouncer: RTL and testbench
======================================

// Module: spv_input_debouncer
// PURPOSE
//   Conditions the three raw switch inputs S, P, V before they reach the LED
//   decision logic. Each channel is synchronised with a 2-flop synchroniser,
//   then debounced by a per-channel counter FSM. Clean outputs drive S/P/V of
//   the downstream combinational stage directly. Channel order is [2]=S, [1]=P, [0]=V.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive synced cycles a new level must hold before
//                       it is accepted; legal range 1..65535
//   CNT_W            derived localparam = $clog2(DEBOUNCE_CYCLES+1); not overridable
// PORTS
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   raw        in   3  asynchronous switch levels {S,P,V}
//   clean      out  3  debounced, synchronous {S,P,V} to the LED logic
//   change     out  1  one-cycle pulse when any clean bit updates
//   rise       out  3  [EDGE_DETECT_EN only] per-bit 0->1 pulse of clean
//   fall       out  3  [EDGE_DETECT_EN only] per-bit 1->0 pulse of clean
// BEHAVIOUR
//   Reset (async assert, sync release): sync1/sync2=000, clean=000,
//     all counters=0, all FSMs=STABLE, change=0, rise/fall=000.
//   Sync: sync1<=raw; sync2<=sync1. Only sync2 feeds the debouncer.
//   Per-channel FSM, evaluated on every rising edge:
//     STABLE:   sync2==clean -> stay, cnt=0.
//               sync2!=clean -> if DEBOUNCE_CYCLES==1: clean<=sync2, stay STABLE;
//               else cnt<=1, go COUNTING.
//     COUNTING: sync2==clean -> cnt<=0, go STABLE (glitch rejected).
//               sync2!=clean and cnt==DEBOUNCE_CYCLES-1 -> clean<=sync2,
//               cnt<=0, go STABLE.
//               else cnt<=cnt+1.
//   Latency: with the first edge that samples a new raw level as edge 1, clean
//     updates on edge DEBOUNCE_CYCLES+2, if raw held through edge DEBOUNCE_CYCLES+1.
//   A raw pulse shorter than DEBOUNCE_CYCLES cycles never reaches clean.
//   change: registered; high during exactly the cycle in which the new clean
//     value is first visible; one pulse even if several bits update on one edge.
//   Channels are fully independent; simultaneous transitions each time out
//     independently.
//   Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//   Reset mid-count: count discarded, clean forced to 000; after release a
//     held level is re-qualified from scratch (full 2+DEBOUNCE_CYCLES latency).
//   Raw toggling every cycle: clean holds its value indefinitely, change stays 0.
// CONFIGURATION
//   EDGE_DETECT_EN defined: rise/fall ports exist; rise[i]=clean[i]&~clean_q[i],
//     fall[i]=~clean[i]&clean_q[i], both registered-aligned with change
//     (high in same cycle as change); reset 000.
//   EDGE_DETECT_EN undefined: rise/fall ports and logic absent; all other
//     behaviour identical.
// TESTING (DEBOUNCE_CYCLES=4, clk period 10)
//   1. rst=1 with raw=111 -> clean=000, change=0 throughout; release -> clean=111
//      on edge 6 after release, single change pulse.
//   2. raw 000->100 held -> clean=100 on edge 6, change=1 for that one cycle
//      only; rise=100, fall=000 when EDGE_DETECT_EN.
//   3. raw P=1 for 3 cycles then 0 -> clean stays 000, change never asserts.
//   4. raw 000->111 in one cycle -> all three clean bits update on the same
//      edge, exactly one change pulse.
//   5. raw S=1, rst pulsed after 3 edges -> clean=000; after release clean[2]=1
//      on edge 6 of the re-qualification, not earlier.
//   6. raw 111->000 held (EDGE_DETECT_EN) -> fall=111, rise=000, change=1 for one
//      cycle; all eight {S,P,V} combinations reach clean in turn.

Source files
------------

// File: rtl/spv_input_debouncer.sv
// Per-channel 2-flop synchroniser + counter debouncer for the {S,P,V} switches.
// Define EDGE_DETECT_EN to add the registered rise/fall pulse outputs.
module spv_input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] raw,
   output logic [2:0] clean,
   output logic       change
`ifdef EDGE_DETECT_EN
   ,
   output logic [2:0] rise,
   output logic [2:0] fall
`endif
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      STABLE,
      COUNTING
   } state_t;

   logic [2:0]       sync1_q;
   logic [2:0]       sync2_q;
   logic [2:0]       clean_q;
   logic [2:0]       clean_d;
   logic             change_q;
   logic             change_d;
   state_t           state_q [3];
   state_t           state_d [3];
   logic [CNT_W-1:0] cnt_q   [3];
   logic [CNT_W-1:0] cnt_d   [3];
`ifdef EDGE_DETECT_EN
   logic [2:0]       rise_q;
   logic [2:0]       rise_d;
   logic [2:0]       fall_q;
   logic [2:0]       fall_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         clean_q  <= '0;
         change_q <= 1'b0;
         for (int unsigned i = 0; i < 3; i++) begin
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
         end
`ifdef EDGE_DETECT_EN
         rise_q   <= '0;
         fall_q   <= '0;
`endif
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         clean_q  <= clean_d;
         change_q <= change_d;
         for (int unsigned i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
`ifdef EDGE_DETECT_EN
         rise_q   <= rise_d;
         fall_q   <= fall_d;
`endif
      end
   end

   always_comb begin
      clean_d = clean_q;
      for (int unsigned i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            STABLE: begin
               if (sync2_q[i] != clean_q[i]) begin
                  // A one-cycle qualification window accepts on the first mismatch.
                  if (DEBOUNCE_CYCLES == 1) begin
                     clean_d[i] = sync2_q[i];
                  end else begin
                     cnt_d[i]   = CNT_W'(1);
                     state_d[i] = COUNTING;
                  end
               end else begin
                  cnt_d[i] = '0;
               end
            end
            COUNTING: begin
               if (sync2_q[i] == clean_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = STABLE;
               end else if (cnt_q[i] == CNT_LAST) begin
                  clean_d[i] = sync2_q[i];
                  cnt_d[i]   = '0;
                  state_d[i] = STABLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = STABLE;
            end
         endcase
      end
   end

   // Pulses are computed from the pending update so they land with the new clean value.
   always_comb begin
      change_d = |(clean_d ^ clean_q);
`ifdef EDGE_DETECT_EN
      rise_d   = clean_d & ~clean_q;
      fall_d   = ~clean_d & clean_q;
`endif
   end

   assign clean  = clean_q;
   assign change = change_q;
`ifdef EDGE_DETECT_EN
   assign rise   = rise_q;
   assign fall   = fall_q;
`endif

endmodule

// File: tb/tb_spv_input_debouncer.sv
// Self-checking bench for spv_input_debouncer (DEBOUNCE_CYCLES=4); rise/fall
// are checked only when EDGE_DETECT_EN is defined.
module tb_spv_input_debouncer;

   localparam int unsigned D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] raw = 3'b111;
   logic [2:0] clean;
   logic       change;
`ifdef EDGE_DETECT_EN
   logic [2:0] rise;
   logic [2:0] fall;
`endif

   int checks   = 0;
   int failures = 0;

   spv_input_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw),
      .clean  (clean),
      .change (change)
`ifdef EDGE_DETECT_EN
      ,
      .rise   (rise),
      .fall   (fall)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: a bit of clean flips once its last D synchronised samples
   // all disagree with it.
   logic [2:0] m_s1, m_s2, m_clean, m_rise, m_fall;
   logic       m_change;
   logic [2:0] m_win[$];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_clean = '0;
      m_rise = '0; m_fall = '0; m_change = 1'b0;
      m_win.delete();
   endtask

   task automatic model_edge(input logic [2:0] r, input logic rr);
      logic [2:0] used;
      logic [2:0] upd;
      logic       all_diff;
      if (rr) begin
         model_reset();
      end else begin
         used = m_s2;
         m_s2 = m_s1;
         m_s1 = r;
         m_win.push_back(used);
         if (m_win.size() > D) void'(m_win.pop_front());
         upd = '0;
         if (m_win.size() == D) begin
            for (int i = 0; i < 3; i++) begin
               all_diff = 1'b1;
               for (int k = 0; k < int'(D); k++)
                  if (m_win[k][i] == m_clean[i]) all_diff = 1'b0;
               upd[i] = all_diff;
            end
         end
         m_rise   = upd & ~m_clean;
         m_fall   = upd & m_clean;
         m_change = |upd;
         m_clean  = m_clean ^ upd;
      end
   endtask

   function automatic logic [9:0] dut_vec();
`ifdef EDGE_DETECT_EN
      return {clean, change, rise, fall};
`else
      return {clean, change, 6'b0};
`endif
   endfunction

   function automatic logic [9:0] model_vec();
`ifdef EDGE_DETECT_EN
      return {m_clean, m_change, m_rise, m_fall};
`else
      return {m_clean, m_change, 6'b0};
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge(raw, rst);
      #1;
   endtask

   task automatic reset_dut(input logic [2:0] r);
      rst = 1'b1;
      model_reset();
      raw = r;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      for (int e = 0; e < 3; e++) begin
         tick();
         checks++;
         if ({clean, change} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold got clean=%b change=%b exp 000/0", clean, change);
         end
      end
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (clean !== ((e >= 6) ? 3'b111 : 3'b000) || change !== (e == 6)) begin
            failures++;
            $display("FAIL reset_release e=%0d got clean=%b change=%b", e, clean, change);
         end
      end
   endtask

   task automatic test_single_rise();
      reset_dut(3'b000);
      raw = 3'b100;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (clean !== ((e >= 6) ? 3'b100 : 3'b000) || change !== (e == 6)) begin
            failures++;
            $display("FAIL single_rise e=%0d got clean=%b change=%b", e, clean, change);
         end
`ifdef EDGE_DETECT_EN
         checks++;
         if (rise !== ((e == 6) ? 3'b100 : 3'b000) || fall !== 3'b000) begin
            failures++;
            $display("FAIL single_rise_edge e=%0d got rise=%b fall=%b", e, rise, fall);
         end
`endif
      end
   endtask

   task automatic test_glitch();
      reset_dut(3'b000);
      raw = 3'b010;
      for (int e = 1; e <= 12; e++) begin
         if (e == 4) raw = 3'b000;
         tick();
         checks++;
         if (clean !== 3'b000 || change !== 1'b0) begin
            failures++;
            $display("FAIL glitch e=%0d got clean=%b change=%b exp 000/0", e, clean, change);
         end
      end
   endtask

   task automatic test_simultaneous();
      int pulses;
      pulses = 0;
      reset_dut(3'b000);
      raw = 3'b111;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (change === 1'b1) pulses++;
         checks++;
         if (clean !== ((e >= 6) ? 3'b111 : 3'b000)) begin
            failures++;
            $display("FAIL simultaneous e=%0d got clean=%b", e, clean);
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL simultaneous_pulses got %0d exp 1", pulses);
      end
   endtask

   task automatic test_reset_midcount();
      reset_dut(3'b000);
      raw = 3'b100;
      tick(); tick(); tick();
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (clean !== 3'b000 || change !== 1'b0) begin
         failures++;
         $display("FAIL midcount_reset got clean=%b change=%b exp 000/0", clean, change);
      end
      tick(); tick();
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (clean !== ((e >= 6) ? 3'b100 : 3'b000)) begin
            failures++;
            $display("FAIL midcount_requal e=%0d got clean=%b", e, clean);
         end
      end
   endtask

   task automatic test_all_combos();
      reset_dut(3'b111);
      repeat (8) tick();
      raw = 3'b000;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (clean !== ((e >= 6) ? 3'b000 : 3'b111) || change !== (e == 6)) begin
            failures++;
            $display("FAIL fall_all e=%0d got clean=%b change=%b", e, clean, change);
         end
`ifdef EDGE_DETECT_EN
         checks++;
         if (fall !== ((e == 6) ? 3'b111 : 3'b000) || rise !== 3'b000) begin
            failures++;
            $display("FAIL fall_all_edge e=%0d got rise=%b fall=%b", e, rise, fall);
         end
`endif
      end
      for (int c = 0; c < 8; c++) begin
         raw = 3'(c);
         repeat (8) tick();
         checks++;
         if (clean !== 3'(c)) begin
            failures++;
            $display("FAIL combo got clean=%b exp %b", clean, 3'(c));
         end
      end
   endtask

   task automatic test_toggle();
      for (int e = 0; e < 40; e++) begin
         raw = {2'b11, e[0]};
         tick();
         checks++;
         if (clean !== 3'b111 || change !== 1'b0) begin
            failures++;
            $display("FAIL toggle e=%0d got clean=%b change=%b exp 111/0", e, clean, change);
         end
      end
   endtask

   task automatic test_random();
      raw = 3'b111;
      for (int e = 0; e < 800; e++) begin
         if ($urandom_range(0, 4) == 0) raw = 3'($urandom_range(0, 7));
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL random e=%0d got %b exp %b", e, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      raw = 3'b111;
      test_reset();
      test_single_rise();
      test_glitch();
      test_simultaneous();
      test_reset_midcount();
      test_all_combos();
      test_toggle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
